div_req_sequencer: RTL and testbench

DIV_REQ_SEQUENCER -- requirements
Module: div_req_sequencer

---
 rtl/div_req_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_div_req_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_req_sequencer.sv
// Request sequencer in front of a multi-cycle DivisorUnit: queues divide requests,
// issues them one at a time, short-circuits zero divisors and holds each response until taken.
module div_req_sequencer #(
   parameter int PARALLELISM = 32,
   parameter int DEPTH       = 4,
   parameter int TAG_W       = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_usigned,
   input  logic [PARALLELISM-1:0] req_dividend,
   input  logic [PARALLELISM-1:0] req_divisor,
   input  logic [TAG_W-1:0]       req_tag,
   output logic                   div_valid,
   output logic                   div_usigned,
   output logic [PARALLELISM-1:0] div_dividend,
   output logic [PARALLELISM-1:0] div_divisor,
   input  logic [PARALLELISM-1:0] div_quotient,
   input  logic [PARALLELISM-1:0] div_reminder,
   input  logic                   div_res_ready,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [PARALLELISM-1:0] rsp_quotient,
   output logic [PARALLELISM-1:0] rsp_reminder,
   output logic [TAG_W-1:0]       rsp_tag,
   output logic                   rsp_divzero
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int ENTRY_W = 1 + 2 * PARALLELISM + TAG_W;
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   logic [ENTRY_W-1:0]     fifoMem [DEPTH];
   logic [PTR_W-1:0]       wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]       rdPtr_q, rdPtr_d;
   logic [PTR_W:0]         count_q, count_d;
   logic                   full, empty, push, pop;

   logic [ENTRY_W-1:0]     headEntry;
   logic                   headUsigned;
   logic [PARALLELISM-1:0] headDividend;
   logic [PARALLELISM-1:0] headDivisor;
   logic [TAG_W-1:0]       headTag;
   logic                   headDivZero;

   logic [1:0]             state_q, state_d;
   logic                   opUsigned_q, opUsigned_d;
   logic [PARALLELISM-1:0] opDividend_q, opDividend_d;
   logic [PARALLELISM-1:0] opDivisor_q, opDivisor_d;
   logic [TAG_W-1:0]       opTag_q, opTag_d;
   logic [PARALLELISM-1:0] rspQuot_q, rspQuot_d;
   logic [PARALLELISM-1:0] rspRem_q, rspRem_d;
   logic [TAG_W-1:0]       rspTag_q, rspTag_d;
   logic                   rspDivZero_q, rspDivZero_d;

   // A full FIFO refuses pushes even when a pop happens in the same cycle.
   assign full      = (count_q == FULL_COUNT);
   assign empty     = (count_q == '0);
   assign req_ready = !full;
   assign push      = req_valid && !full;
   assign pop       = (state_q == S_IDLE) && !empty;

   assign headEntry = fifoMem[rdPtr_q];
   assign {headUsigned, headDividend, headDivisor, headTag} = headEntry;
   assign headDivZero = (headDivisor == '0);

   always_ff @(posedge clk) begin
      if (push) begin
         fifoMem[wrPtr_q] <= {req_usigned, req_dividend, req_divisor, req_tag};
      end
   end

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (push) begin
         wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (pop) begin
         rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W + 1)'(1);
         2'b01:   count_d = count_q - (PTR_W + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Zero divisors never reach the DivisorUnit; their response is built directly on pop.
   always_comb begin
      state_d      = state_q;
      opUsigned_d  = opUsigned_q;
      opDividend_d = opDividend_q;
      opDivisor_d  = opDivisor_q;
      opTag_d      = opTag_q;
      rspQuot_d    = rspQuot_q;
      rspRem_d     = rspRem_q;
      rspTag_d     = rspTag_q;
      rspDivZero_d = rspDivZero_q;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               opUsigned_d  = headUsigned;
               opDividend_d = headDividend;
               opDivisor_d  = headDivisor;
               opTag_d      = headTag;
               if (headDivZero) begin
                  rspQuot_d    = {PARALLELISM{1'b1}};
                  rspRem_d     = headDividend;
                  rspTag_d     = headTag;
                  rspDivZero_d = 1'b1;
                  state_d      = S_HOLD;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (div_res_ready) begin
               rspQuot_d    = div_quotient;
               rspRem_d     = div_reminder;
               rspTag_d     = opTag_q;
               rspDivZero_d = 1'b0;
               state_d      = S_HOLD;
            end
         end
         S_HOLD: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q      <= '0;
         rdPtr_q      <= '0;
         count_q      <= '0;
         state_q      <= S_IDLE;
         opUsigned_q  <= 1'b0;
         opDividend_q <= '0;
         opDivisor_q  <= '0;
         opTag_q      <= '0;
         rspQuot_q    <= '0;
         rspRem_q     <= '0;
         rspTag_q     <= '0;
         rspDivZero_q <= 1'b0;
      end else begin
         wrPtr_q      <= wrPtr_d;
         rdPtr_q      <= rdPtr_d;
         count_q      <= count_d;
         state_q      <= state_d;
         opUsigned_q  <= opUsigned_d;
         opDividend_q <= opDividend_d;
         opDivisor_q  <= opDivisor_d;
         opTag_q      <= opTag_d;
         rspQuot_q    <= rspQuot_d;
         rspRem_q     <= rspRem_d;
         rspTag_q     <= rspTag_d;
         rspDivZero_q <= rspDivZero_d;
      end
   end

   assign div_valid    = (state_q == S_ISSUE);
   assign div_usigned  = opUsigned_q;
   assign div_dividend = opDividend_q;
   assign div_divisor  = opDivisor_q;

   assign rsp_valid    = (state_q == S_HOLD);
   assign rsp_quotient = rspQuot_q;
   assign rsp_reminder = rspRem_q;
   assign rsp_tag      = rspTag_q;
   assign rsp_divzero  = rspDivZero_q;

endmodule

// File: tb/tb_div_req_sequencer.sv
// Bench for div_req_sequencer: directed scenarios plus randomized traffic,
// with a behavioural DivisorUnit and an in-order response scoreboard.
module tb_div_req_sequencer;

   localparam int PW    = 32;
   localparam int DEPTH = 4;
   localparam int TW    = 4;

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_usigned;
   logic [PW-1:0] req_dividend;
   logic [PW-1:0] req_divisor;
   logic [TW-1:0] req_tag;
   logic          div_valid;
   logic          div_usigned;
   logic [PW-1:0] div_dividend;
   logic [PW-1:0] div_divisor;
   logic [PW-1:0] div_quotient;
   logic [PW-1:0] div_reminder;
   logic          div_res_ready;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [PW-1:0] rsp_quotient;
   logic [PW-1:0] rsp_reminder;
   logic [TW-1:0] rsp_tag;
   logic          rsp_divzero;

   int            assertCount = 0;
   int            failCount   = 0;
   int            divPulses   = 0;
   int            rspCount    = 0;
   int            acceptCount = 0;
   int            duCount     = 0;
   int            duLatency   = 33;
   logic          forcePulse  = 1'b0;
   logic [2*PW:0] duOps       = '0;
   logic [127:0]  expQ [$];
   logic [2*PW:0] issQ [$];

   div_req_sequencer #(.PARALLELISM(PW), .DEPTH(DEPTH), .TAG_W(TW)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_usigned  (req_usigned),
      .req_dividend (req_dividend),
      .req_divisor  (req_divisor),
      .req_tag      (req_tag),
      .div_valid    (div_valid),
      .div_usigned  (div_usigned),
      .div_dividend (div_dividend),
      .div_divisor  (div_divisor),
      .div_quotient (div_quotient),
      .div_reminder (div_reminder),
      .div_res_ready(div_res_ready),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_quotient (rsp_quotient),
      .rsp_reminder (rsp_reminder),
      .rsp_tag      (rsp_tag),
      .rsp_divzero  (rsp_divzero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Truncating divide as the DivisorUnit defines it; zero divisor gives all ones / dividend.
   function automatic logic [2*PW-1:0] refQuotRem(input logic us, input logic [PW-1:0] a, input logic [PW-1:0] b);
      logic signed [PW-1:0] sa;
      logic signed [PW-1:0] sb;
      if (b == '0) return {{PW{1'b1}}, a};
      if (us) return {a / b, a % b};
      if (a == {1'b1, {(PW-1){1'b0}}} && b == {PW{1'b1}}) return {a, {PW{1'b0}}};
      sa = a;
      sb = b;
      return {PW'(sa / sb), PW'(sa % sb)};
   endfunction

   function automatic logic [127:0] refRsp(input logic us, input logic [PW-1:0] a, input logic [PW-1:0] b, input logic [TW-1:0] t);
      return {59'd0, refQuotRem(us, a, b), t, (b == '0)};
   endfunction

   task automatic applyStimulus(input logic us, input logic [PW-1:0] a, input logic [PW-1:0] b, input logic [TW-1:0] t);
      req_valid    = 1'b1;
      req_usigned  = us;
      req_dividend = a;
      req_divisor  = b;
      req_tag      = t;
   endtask

   task automatic waitRsp(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 200);
   endtask

   // Negedge monitor: records accepted requests, checks issues and responses in order.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            duCount = 0;
            expQ.delete();
            issQ.delete();
         end else begin
            if (req_valid && req_ready) begin
               acceptCount++;
               expQ.push_back(refRsp(req_usigned, req_dividend, req_divisor, req_tag));
               if (req_divisor != '0) issQ.push_back({req_usigned, req_dividend, req_divisor});
            end
            if (div_valid) begin
               divPulses++;
               if (issQ.size() == 0) checkOutput("div_unexpected", 1, 0);
               else checkOutput("div_operands", {div_usigned, div_dividend, div_divisor}, issQ.pop_front());
               duOps   = {div_usigned, div_dividend, div_divisor};
               duCount = duLatency;
            end else if (duCount > 0) begin
               checkOutput("div_op_stable", {div_usigned, div_dividend, div_divisor}, duOps);
            end
            if (rsp_valid) checkOutput("div_valid_in_hold", div_valid, 0);
            if (rsp_valid && rsp_ready) begin
               rspCount++;
               if (expQ.size() == 0) checkOutput("rsp_unexpected", 1, 0);
               else checkOutput("rsp_fields", {59'd0, rsp_quotient, rsp_reminder, rsp_tag, rsp_divzero}, expQ.pop_front());
            end
         end
      end
   end

   // Behavioural DivisorUnit: result pulse a fixed number of cycles after each start pulse.
   initial begin
      div_res_ready = 1'b0;
      div_quotient  = '0;
      div_reminder  = '0;
      forever begin
         @(posedge clk);
         #1;
         div_res_ready = 1'b0;
         if (forcePulse) begin
            div_res_ready = 1'b1;
            div_quotient  = $urandom;
            div_reminder  = $urandom;
         end else if (duCount > 0) begin
            duCount--;
            if (duCount == 0) begin
               {div_quotient, div_reminder} = refQuotRem(duOps[2*PW], duOps[2*PW-1:PW], duOps[PW-1:0]);
               div_res_ready = 1'b1;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int lat;
      int base;
      int accBase;
      int n;
      int sel;
      rst = 1'b1;
      req_valid = 1'b0;
      req_usigned = 1'b0;
      req_dividend = '0;
      req_divisor = '0;
      req_tag = '0;
      rsp_ready = 1'b0;

      // Reset held for three cycles.
      repeat (3) @(negedge clk);
      checkOutput("rst_req_ready", req_ready, 1);
      checkOutput("rst_div_valid", div_valid, 0);
      checkOutput("rst_div_fields", {div_usigned, div_dividend, div_divisor}, 0);
      checkOutput("rst_rsp_valid", rsp_valid, 0);
      checkOutput("rst_rsp_fields", {rsp_quotient, rsp_reminder, rsp_tag, rsp_divzero}, 0);

      // Signed request pushed on the first edge after release, 33-cycle DivisorUnit.
      @(posedge clk);
      #1;
      rst = 1'b0;
      duLatency = 33;
      applyStimulus(1'b0, 32'hFFFFFF8B, 32'h0000000A, 4'd3);
      @(negedge clk);
      checkOutput("first_accept", req_ready, 1);
      waitRsp(lat);
      checkOutput("signed_latency", lat, 36);
      checkOutput("signed_div_pulses", divPulses, 1);
      checkOutput("signed_quot", rsp_quotient, 32'hFFFFFFF5);
      checkOutput("signed_rem", rsp_reminder, 32'hFFFFFFF9);
      checkOutput("signed_tag", rsp_tag, 3);
      checkOutput("signed_divzero", rsp_divzero, 0);

      // Backpressure: ten cycles in HOLD with rsp_ready low.
      repeat (10) begin
         @(negedge clk);
         checkOutput("hold_stable", {rsp_valid, rsp_quotient, rsp_reminder, rsp_tag, rsp_divzero},
                     {1'b1, 32'hFFFFFFF5, 32'hFFFFFFF9, 4'd3, 1'b0});
      end
      checkOutput("hold_no_issue", divPulses, 1);
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      checkOutput("rsp_released", rsp_valid, 0);

      // Zero divisor bypasses the DivisorUnit.
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 32'h00000064, 32'h0, 4'd5);
      waitRsp(lat);
      checkOutput("zero_latency", lat, 2);
      checkOutput("zero_quot", rsp_quotient, 32'hFFFFFFFF);
      checkOutput("zero_rem", rsp_reminder, 32'h00000064);
      checkOutput("zero_tag", rsp_tag, 5);
      checkOutput("zero_divzero", rsp_divzero, 1);
      checkOutput("zero_no_issue", divPulses, 1);
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;

      // Capacity: six back-to-back requests with responses blocked.
      duLatency = 3;
      base = rspCount;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         applyStimulus(1'b1, 32'(100 + i), 32'd7, TW'(i));
         @(negedge clk);
         checkOutput($sformatf("full_accept_%0d", i), req_ready, (i < 5) ? 1 : 0);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready && n < 500);
      checkOutput("full_tag5_wait", n, 3);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      n = 0;
      while ((expQ.size() != 0 || rsp_valid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      checkOutput("full_drain_empty", expQ.size(), 0);
      checkOutput("full_rsp_count", rspCount - base, 6);

      // Reset while waiting on the DivisorUnit, then a stray result pulse.
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      duLatency = 33;
      applyStimulus(1'b0, 32'd1000, 32'd7, 4'd9);
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 32'd50, 32'd3, 4'd10);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rsp_ready = 1'b1;
      base = divPulses;
      @(negedge clk);
      forcePulse = 1'b1;
      @(posedge clk);
      #2;
      forcePulse = 1'b0;
      repeat (10) begin
         @(negedge clk);
         checkOutput("rstwait_rsp_valid", rsp_valid, 0);
      end
      checkOutput("rstwait_no_issue", divPulses - base, 0);
      checkOutput("rstwait_rsp_quot", rsp_quotient, 0);
      checkOutput("rstwait_req_ready", req_ready, 1);

      // Randomized traffic against the scoreboard.
      base = rspCount;
      accBase = acceptCount;
      for (int c = 0; c < 800; c++) begin
         @(posedge clk);
         #1;
         req_valid   = ($urandom_range(0, 1) == 1);
         req_usigned = ($urandom_range(0, 1) == 1);
         req_tag     = TW'($urandom);
         sel = $urandom_range(0, 9);
         if (sel < 2) req_divisor = '0;
         else if (sel == 2) req_divisor = '1;
         else if (sel == 3) req_divisor = PW'($urandom_range(1, 15));
         else req_divisor = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0) req_dividend = 32'h80000000;
         else if (sel == 1) req_dividend = PW'($urandom_range(0, 200));
         else req_dividend = $urandom;
         rsp_ready = ($urandom_range(0, 9) < 7);
         duLatency = $urandom_range(1, 6);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      n = 0;
      while ((expQ.size() != 0 || rsp_valid) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("rand_drain_empty", expQ.size(), 0);
      checkOutput("rand_rsp_count", rspCount - base, acceptCount - accBase);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
